// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the MEMBANK arbiter
// state encoding, port ids and default geometry
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 16;
  localparam int MEM_LAT_DEF = 1;

endpackage

// File: rtl/mem_arb_if.sv
// mem_arb_if: requester ports plus MEMBANK control bus
// slave = arbiter side, master = requesters/bank side
interface mem_arb_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_ack;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_ack;
  logic [DATA_W-1:0] p1_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              grant;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_rdata,
    output p0_ack, p0_rdata,
    output p1_ack, p1_rdata,
    output mem_addr, mem_wdata,
    output mem_read, mem_write,
    output busy, grant
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_rdata,
    input  p0_ack, p0_rdata,
    input  p1_ack, p1_rdata,
    input  mem_addr, mem_wdata,
    input  mem_read, mem_write,
    input  busy, grant
  );

endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin front end for the MEMBANK
// turns level req/ack handshakes into one-cycle bank strobes
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic      CLK,
  input  logic      RST_N,
  mem_arb_if.slave  bus
);

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t            state;
  logic              last_grant;
  logic              grant_q;
  logic              we_q;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic              rd_q;
  logic              wr_q;
  logic              ack0_q;
  logic              ack1_q;
  logic              busy_q;

  logic both;
  logic pick;

  // on a tie, the port that did not win last time goes next
  assign both = bus.p0_req & bus.p1_req;
  assign pick = both ? ~last_grant : bus.p1_req;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      last_grant <= PORT_DATA;
      grant_q    <= PORT_FETCH;
      we_q       <= 1'b0;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.p0_req | bus.p1_req) begin
            grant_q    <= pick;
            last_grant <= pick;
            busy_q     <= 1'b1;
            state      <= ISSUE;
            if (pick == PORT_DATA) begin
              addr_q  <= bus.p1_addr;
              wdata_q <= bus.p1_wdata;
              we_q    <= bus.p1_we;
              rd_q    <= ~bus.p1_we;
              wr_q    <= bus.p1_we;
            end else begin
              addr_q  <= bus.p0_addr;
              wdata_q <= bus.p0_wdata;
              we_q    <= bus.p0_we;
              rd_q    <= ~bus.p0_we;
              wr_q    <= bus.p0_we;
            end
          end
        end
        ISSUE: begin
          rd_q  <= 1'b0;
          wr_q  <= 1'b0;
          cnt   <= CNT_INIT;
          state <= WAIT;
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            // bank floats its output after a write
            if (!we_q) begin
              if (grant_q == PORT_DATA)
                rdata1_q <= bus.mem_rdata;
              else
                rdata0_q <= bus.mem_rdata;
            end
            if (grant_q == PORT_DATA)
              ack1_q <= 1'b1;
            else
              ack0_q <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          ack0_q <= 1'b0;
          ack1_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_read  = rd_q;
  assign bus.mem_write = wr_q;
  assign bus.p0_ack    = ack0_q;
  assign bus.p1_ack    = ack1_q;
  assign bus.p0_rdata  = rdata0_q;
  assign bus.p1_rdata  = rdata1_q;
  assign bus.busy      = busy_q;
  assign bus.grant     = grant_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences every access to the 256x16 MEMBANK and shares it between two requesters: port 0 (instruction fetch) and port 1 (load/store unit).
- Converts level req/ack handshakes into the single-cycle mem_read/mem_write strobes the bank needs. The bank latches a strobe's rising edge and acts on the following CLK edge.
- Sits between the control unit/datapath and MEMBANK; it is the only driver of the bank's control inputs.

Parameters:
- ADDR_W, 8: address width; must match the bank.
- DATA_W, 16: data width.
- MEM_LAT, 1: number of WAIT cycles before read data is captured. Legal range 1..15; this sets a 4-bit counter.

Ports:
- CLK  in  1  system clock; all state changes on posedge.
- RST_N  in  1  asynchronous reset, active low.
- p0_req  in  1  port 0 request; held until p0_ack.
- p0_we  in  1  port 0: 1 = write, 0 = read.
- p0_addr  in  ADDR_W  port 0 address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_ack  out  1  port 0 completion; high for exactly one cycle.
- p0_rdata  out  DATA_W  port 0 read data; valid with p0_ack, held until the next port 0 read completes.
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata: same as port 0, for port 1.
- mem_addr  out  ADDR_W  to bank address.
- mem_wdata  out  DATA_W  to bank data_in.
- mem_read  out  1  to bank read strobe.
- mem_write  out  1  to bank write strobe.
- mem_rdata  in  DATA_W  from bank data_out.
- busy  out  1  high whenever state is not IDLE.
- grant  out  1  port currently owning the bank; meaningful only while busy.

Behaviour:
- All outputs are registered.
- Reset values (RST_N low, takes effect immediately):
  - state IDLE; mem_read = mem_write = 0.
  - mem_addr, mem_wdata, p0_rdata, p1_rdata = 0.
  - p0_ack = p1_ack = 0; busy = 0; grant = 0.
  - last_grant = 1, so port 0 wins the first tie.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: the requests are sampled here and only here.
  - No request: stay in IDLE.
  - One request: grant that port.
  - Both requesting: grant the port != last_grant (round-robin).
  - On accept at edge E0: latch addr, we and wdata into mem_addr/mem_wdata; set mem_read = ~we or mem_write = we; update last_grant and grant; go to ISSUE.
- ISSUE, edge E1 (the bank performs the access on this edge): drop both strobes to 0; load cnt = MEM_LAT-1; go to WAIT.
- WAIT:
  - If cnt != 0: decrement cnt.
  - If cnt == 0: for a read, capture mem_rdata into the granted port's rdata. For a write, leave rdata unchanged and ignore mem_rdata (the bank drives Z after a write). Set the granted port's ack = 1; go to DONE.
- DONE: ack returns to 0; go to IDLE.
  - This cycle gives the requester time to drop or renew req before IDLE samples again.
- Latency: with MEM_LAT = 1, ack is high in the cycle following E2. Service rate is one access per MEM_LAT+3 cycles.
- Strobe rules:
  - Each strobe is high for exactly one cycle.
  - mem_read and mem_write are never high together.
  - There is always at least one low cycle between strobes, so every access produces a fresh rising edge at the bank.
- mem_addr and mem_wdata are held from accept until the next accept.
- Requester inputs changing after accept are ignored; the access uses the latched values.
- req dropped mid-access: the access completes and ack still pulses.
- Reset asserted mid-access: everything returns to reset values at once. No ack is produced; a strobe that is high is cut short.
- A requester that holds req across its ack is treated as a new request; it competes normally under round-robin in the next IDLE.

Decomposition:
- Package mem_arb_pkg holds:
  - the state encoding (IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3);
  - the port IDs PORT_FETCH = 1'b0 and PORT_DATA = 1'b1;
  - the default ADDR_W, DATA_W and MEM_LAT.
- No sub-module; the round-robin pick is two lines of logic. Bench pairs the block with a real MEMBANK instance.

Test Plan:
- Reset: hold RST_N low for 3 cycles with both reqs high -> all outputs 0, busy 0, no strobe; release -> first accept goes to port 0.
- Port 0 read of 0x00 (bank preloaded with 0x0321):
  - exactly one mem_read pulse with mem_addr = 0x00;
  - p0_ack high exactly one cycle, 3 cycles after accept;
  - p0_rdata = 0x0321 and stays there after the ack.
- Port 1 write of 0xBEEF to 0x10, then a port 1 read of 0x10 -> one mem_write pulse, then p1_rdata = 0xBEEF; p1_rdata is unchanged (0) after the write ack.
- Both ports continuously requesting reads of 0xFF (p0) and 0xFE (p1) -> grants alternate 0,1,0,1; p0_rdata = 0x0040, p1_rdata = 0x0020; strobes never overlap.
- RST_N pulsed low during WAIT -> no ack, state IDLE, strobes 0; a following read of 0x01 returns 0x1421.
- MEM_LAT = 3, port 0 read -> ack is 5 cycles after accept; mem_read is high for exactly one cycle.
